// File: rtl/game_sprite_motion_pkg.sv
// Common definitions for the sprite motion block; screen size comes from game_config.vh.
package game_sprite_motion_pkg;

`include "game_config.vh"

  // Two's-complement negation that maps the most negative value to the most positive one.
  function automatic logic [7:0] neg_sat8(input logic [7:0] v, input int unsigned w);
    logic [7:0] min_v;
    logic [7:0] max_v;
    min_v = 8'd1 << (w - 1);
    max_v = min_v - 8'd1;
    if (v == min_v) begin
      neg_sat8 = max_v;
    end else begin
      neg_sat8 = (8'd0 - v) & ((8'd1 << w) - 8'd1);
    end
  endfunction

endpackage

// File: rtl/game_config.vh
// Shared screen geometry for the game blocks; included inside packages.
`ifndef GAME_CONFIG_VH
`define GAME_CONFIG_VH

localparam int SCREEN_WIDTH  = 640;
localparam int SCREEN_HEIGHT = 480;

`endif

// File: rtl/game_strobe_gen.sv
// Free-running stride counter 0..PERIOD-1; tick is high while the count is PERIOD-1.
module game_strobe_gen #(
  parameter int PERIOD = 262144
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int CW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/game_sprite_motion.sv
// Sprite position/velocity registers stepped once per stride tick.
// Optional edge bounce on x is enabled by defining GAME_SPRITE_BOUNCE_EN.
module game_sprite_motion
  import game_sprite_motion_pkg::*;
#(
  parameter int X_WIDTH       = 10,
  parameter int Y_WIDTH       = 10,
  parameter int DXY_WIDTH     = 3,
  parameter int SPRITE_WIDTH  = 8,
  parameter int SPRITE_HEIGHT = 8,
  parameter int UPDATE_PERIOD = 262144
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 write_xy,
  input  logic                 write_dxy,
  input  logic                 enable_update,
  input  logic [X_WIDTH-1:0]   x_to_write,
  input  logic [Y_WIDTH-1:0]   y_to_write,
  input  logic [DXY_WIDTH-1:0] dx_to_write,
  input  logic [DXY_WIDTH-1:0] dy_to_write,
  output logic [X_WIDTH-1:0]   x,
  output logic [Y_WIDTH-1:0]   y,
  output logic                 within_screen
);

  localparam logic [X_WIDTH-1:0] X_MAX = X_WIDTH'(SCREEN_WIDTH - SPRITE_WIDTH);
  localparam logic [Y_WIDTH-1:0] Y_MAX = Y_WIDTH'(SCREEN_HEIGHT - SPRITE_HEIGHT);

  logic [X_WIDTH-1:0]   x_q, x_d;
  logic [Y_WIDTH-1:0]   y_q, y_d;
  logic [DXY_WIDTH-1:0] dx_q, dx_d;
  logic [DXY_WIDTH-1:0] dy_q, dy_d;
  logic                 tick;
  logic                 step_s;
  logic [X_WIDTH-1:0]   x_step_s;
  logic [Y_WIDTH-1:0]   y_step_s;

  game_strobe_gen #(.PERIOD(UPDATE_PERIOD)) u_strobe (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  assign step_s   = tick & enable_update & ~write_xy;
  assign x_step_s = x_q + {{(X_WIDTH-DXY_WIDTH){dx_q[DXY_WIDTH-1]}}, dx_q};
  assign y_step_s = y_q + {{(Y_WIDTH-DXY_WIDTH){dy_q[DXY_WIDTH-1]}}, dy_q};

  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    dx_d = dx_q;
    dy_d = dy_q;
    if (write_xy) begin
      x_d = x_to_write;
      y_d = y_to_write;
    end else if (step_s) begin
`ifdef GAME_SPRITE_BOUNCE_EN
      // An out-of-range result with negative dx can only be a wrap below zero.
      if (x_step_s > X_MAX) begin
        x_d  = dx_q[DXY_WIDTH-1] ? '0 : X_MAX;
        dx_d = DXY_WIDTH'(neg_sat8(8'(dx_q), DXY_WIDTH));
      end else begin
        x_d = x_step_s;
      end
`else
      x_d = x_step_s;
`endif
      y_d = y_step_s;
    end else begin
      x_d = x_q;
      y_d = y_q;
    end
    if (write_dxy) begin
      dx_d = dx_to_write;
      dy_d = dy_to_write;
    end else begin
      dy_d = dy_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x_q  <= '0;
      y_q  <= '0;
      dx_q <= '0;
      dy_q <= '0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end

  assign x             = x_q;
  assign y             = y_q;
  assign within_screen = (x_q <= X_MAX) & (y_q <= Y_MAX);

endmodule
